bridge_tx: RTL and testbench
============================

Name: bridge_tx

Overview:
Downstream return path of the ASCII host bridge. It takes a 16-bit read response coming back from the core chain and serialises it as "M" + 4 uppercase hex digits + CR (+ LF) into a byte stream. The byte stream feeds the UART transmitter over a valid/ready handshake. Write transactions produce no response; their returns are ignored.

Parameters:
PREAMBLE, 8'h4D ("M"), first byte of every response.
EMIT_LF, 1, 1: terminate with CR LF (7 bytes total); 0: terminate with CR only (6 bytes total).

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
data_i  in  16  read data returned from the core chain
rw_i  in  1  1 = write (ignored), 0 = read (emit response)
valid_i  in  1  data_i/rw_i qualifier, single-cycle pulse
byte_o  out  8  ASCII byte to the UART transmitter
byte_valid_o  out  1  byte_o is valid
byte_ready_i  in  1  UART transmitter accepts byte_o this cycle
busy_o  out  1  a response is being serialised
overrun_o  out  1  sticky: a read response arrived while busy_o=1

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, byte_o=0, byte_valid_o=0, busy_o=0, overrun_o=0, byte index=0, data latch=0. Reset mid-message aborts it immediately. No partial byte is emitted after reset release.
- FSM states:
  - IDLE: busy_o=0, byte_valid_o=0.
  - SEND: busy_o=1, byte_valid_o=1.
- IDLE -> SEND: on an edge with valid_i=1 and rw_i=0. data_i is latched and the byte index is set to 0. byte_valid_o=1 with byte_o=PREAMBLE from the next cycle (1-cycle latency).
- valid_i with rw_i=1 is ignored in every state, including for overrun.
- SEND: a handshake is byte_valid_o=1 and byte_ready_i=1 on the same edge. On each handshake the index increments and byte_o updates on that same edge. byte_o is stable while waiting for ready.
- Byte sequence, by index:
  - 0: PREAMBLE
  - 1: hex(data[15:12])
  - 2: hex(data[11:8])
  - 3: hex(data[7:4])
  - 4: hex(data[3:0])
  - 5: 8'h0D
  - 6: 8'h0A, only when EMIT_LF=1
- hex(n): n<10 gives 8'h30+n; otherwise 8'h41+(n-10). Uppercase only.
- SEND -> IDLE: on the handshake of the last byte (index 6, or index 5 when EMIT_LF=0). byte_valid_o drops on the next cycle; no bubble byte is emitted.
- Back-to-back: valid_i on the cycle after return to IDLE is accepted. valid_i on the same edge as the final handshake is treated as arriving while busy.
- Read valid_i while in SEND: the response is dropped, the latched data is unchanged, and overrun_o is set to 1. overrun_o is cleared only by reset.
- byte_ready_i held high continuously gives one byte per cycle: a 7-byte response occupies exactly 7 cycles with byte_valid_o=1.
- byte_ready_i while in IDLE has no effect.

Decomposition:
- bridge_pkg holds:
  - CR (8'h0D) and LF (8'h0A) constants;
  - the state enum typedef {IDLE, SEND};
  - a hex_to_ascii(4-bit) -> 8-bit function, shared with bridge_rx's inverse decode.
- No sub-module. Nibble select is a case on the index over the latched data; the FSM and counter are a single process.

Test Plan:
- Read, data_i=16'hBABE, rw_i=0, byte_ready_i=1 held high -> bytes 4D 42 41 42 45 0D 0A on 7 consecutive cycles starting 1 cycle after valid_i; then busy_o=0.
- Write, data_i=16'h1234, rw_i=1 -> byte_valid_o stays 0, busy_o stays 0, overrun_o stays 0.
- Read 16'h0F9A with byte_ready_i toggling 1-of-3 cycles -> byte_o is stable while not ready; sequence is 4D 30 46 39 41 0D 0A, no duplicates, no skips.
- Read 16'hDEAD, then a second read 16'hBEEF 2 cycles later -> output is DEAD only and overrun_o=1. A third read 16'hCAFE after busy_o falls -> 4D 43 41 46 45 0D 0A.
- EOL variant: EMIT_LF=0, read 16'h0000 -> 4D 30 30 30 30 0D (6 bytes), then IDLE.
- Reset: rst_n pulsed low after byte 2 of a read 16'hF00D -> all outputs 0 asynchronously. After release, a read 16'h1234 -> a complete fresh 4D 31 32 33 34 0D 0A.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII host bridge: line terminators, FSM state
// encoding and the nibble-to-ASCII hex helper.
`timescale 1ns/1ps
package bridge_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [BYTE_W-1:0] CR = 8'h0D;
    localparam logic [BYTE_W-1:0] LF = 8'h0A;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
    function automatic logic [BYTE_W-1:0] hex_to_ascii(input logic [3:0] n);
        logic [BYTE_W-1:0] ext;
        ext = BYTE_W'(n);
        return (n < 4'd10) ? (8'h30 + ext) : (8'h37 + ext);
    endfunction

endpackage : bridge_pkg

// File: rtl/bridge_tx.sv
// Serialises a 16-bit read response as PREAMBLE + 4 hex digits + CR (+ LF)
// onto a valid/ready byte stream toward the UART transmitter.
`timescale 1ns/1ps
module bridge_tx
    import bridge_pkg::*;
#(
    parameter logic [7:0] PREAMBLE = 8'h4D,
    parameter bit         EMIT_LF  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rw_i,
    input  logic              valid_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = EMIT_LF ? 3'd6 : 3'd5;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic              read_req;

    // Byte at a given position of the response for the given data word
    function automatic logic [BYTE_W-1:0] byte_at(input logic [IDX_W-1:0] idx,
                                                  input logic [DATA_W-1:0] d);
        logic [BYTE_W-1:0] b;
        case (idx)
            3'd0:    b = PREAMBLE;
            3'd1:    b = hex_to_ascii(d[15:12]);
            3'd2:    b = hex_to_ascii(d[11:8]);
            3'd3:    b = hex_to_ascii(d[7:4]);
            3'd4:    b = hex_to_ascii(d[3:0]);
            3'd5:    b = CR;
            3'd6:    b = LF;
            default: b = '0;
        endcase
        return b;
    endfunction

    assign read_req = valid_i && !rw_i;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (read_req) begin
                    state_d = SEND;
                    data_d  = data_i;
                    idx_d   = '0;
                    byte_d  = byte_at(IDX_W'(0), data_i);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                // A read landing here, even on the final handshake edge, is lost
                if (read_req) begin
                    overrun_d = 1'b1;
                end
                if (byte_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        byte_d  = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        byte_d = byte_at(idx_q + IDX_W'(1), data_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;

endmodule : bridge_tx

// File: tb/tb_bridge_tx.sv
// Bench for bridge_tx: CR+LF and CR-only instances share stimulus and are
// checked every cycle against a message-level reference model.
`timescale 1ns/1ps
module tb_bridge_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic        byte_ready_i;

    logic [7:0]  bo  [2];
    logic        bv  [2];
    logic        bsy [2];
    logic        ovf [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance: 0 = CR LF, 1 = CR only
    logic [7:0]  resp [2][7];
    int          rem  [2];
    int          pos  [2];
    logic        ovr  [2];
    logic [63:0] sent_log [2];

    int ready_mode = 0;
    int ready_cnt  = 0;

    always #5 clk = ~clk;

    bridge_tx #(.PREAMBLE(8'h4D), .EMIT_LF(1'b1)) dut_lf (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .byte_o(bo[0]), .byte_valid_o(bv[0]), .byte_ready_i(byte_ready_i),
        .busy_o(bsy[0]), .overrun_o(ovf[0])
    );

    bridge_tx #(.PREAMBLE(8'h4D), .EMIT_LF(1'b0)) dut_cr (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .byte_o(bo[1]), .byte_valid_o(bv[1]), .byte_ready_i(byte_ready_i),
        .busy_o(bsy[1]), .overrun_o(ovf[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model and per-cycle output checks
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                chk($sformatf("rst_byte%0d", k), 64'(bo[k]), 64'h0);
                chk($sformatf("rst_valid%0d", k), 64'(bv[k]), 64'h0);
                chk($sformatf("rst_busy%0d", k), 64'(bsy[k]), 64'h0);
                chk($sformatf("rst_ovr%0d", k), 64'(ovf[k]), 64'h0);
                rem[k] = 0;
                pos[k] = 0;
                ovr[k] = 1'b0;
            end else begin
                automatic bit was_busy = (rem[k] != 0);
                chk($sformatf("valid%0d", k), 64'(bv[k]), 64'(was_busy));
                chk($sformatf("busy%0d", k), 64'(bsy[k]), 64'(was_busy));
                chk($sformatf("overrun%0d", k), 64'(ovf[k]), 64'(ovr[k]));
                if (was_busy && bv[k]) begin
                    chk($sformatf("byte%0d_idx%0d", k, pos[k]), 64'(bo[k]), 64'(resp[k][pos[k]]));
                    if (byte_ready_i) begin
                        sent_log[k] = {sent_log[k][55:0], bo[k]};
                        pos[k]++;
                        rem[k]--;
                    end
                end
                if (valid_i && !rw_i) begin
                    if (was_busy) begin
                        ovr[k] = 1'b1;
                    end else begin
                        resp[k][0] = 8'h4D;
                        for (int d = 0; d < 4; d++)
                            resp[k][1+d] = hexc((int'(data_i) >> (12 - 4*d)) & 15);
                        resp[k][5] = 8'h0D;
                        resp[k][6] = 8'h0A;
                        pos[k] = 0;
                        rem[k] = (k == 0) ? 7 : 6;
                    end
                end
            end
        end
    end

    // Ready pattern: 0 = always, 1 = one cycle in three, 2 = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: byte_ready_i = 1'b1;
            1: begin
                ready_cnt    = (ready_cnt + 1) % 3;
                byte_ready_i = (ready_cnt == 0);
            end
            default: byte_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic send(input logic [15:0] d, input logic rw);
        tick();
        data_i  = d;
        rw_i    = rw;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (rem[0] == 0 && rem[1] == 0) done = 1'b1;
            else tick();
        end
        if (!done) chk("wait_idle_timeout", 64'h1, 64'h0);
        tick();
    endtask

    task automatic clear_logs();
        sent_log[0] = '0;
        sent_log[1] = '0;
    endtask

    initial begin
        rst_n        = 1'b0;
        data_i       = '0;
        rw_i         = 1'b0;
        valid_i      = 1'b0;
        byte_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; pos[k] = 0; ovr[k] = 1'b0; sent_log[k] = '0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Full-rate read
        ready_mode = 0;
        clear_logs();
        send(16'hBABE, 1'b0);
        wait_idle();
        chk("seq_babe_lf", 64'(sent_log[0][55:0]), 64'h4D_42_41_42_45_0D_0A);
        chk("seq_babe_cr", 64'(sent_log[1][47:0]), 64'h4D_42_41_42_45_0D);

        // Writes produce nothing
        clear_logs();
        send(16'h1234, 1'b1);
        repeat (5) tick();
        chk("write_no_bytes", sent_log[0], 64'h0);

        // Throttled ready
        ready_mode = 1;
        clear_logs();
        send(16'h0F9A, 1'b0);
        wait_idle();
        chk("seq_0f9a_lf", 64'(sent_log[0][55:0]), 64'h4D_30_46_39_41_0D_0A);
        ready_mode = 0;

        // CR-only terminator
        clear_logs();
        send(16'h0000, 1'b0);
        wait_idle();
        chk("seq_0000_cr", 64'(sent_log[1][47:0]), 64'h4D_30_30_30_30_0D);

        // Overrun: second read while busy is dropped
        clear_logs();
        send(16'hDEAD, 1'b0);
        send(16'hBEEF, 1'b0);
        wait_idle();
        chk("seq_dead_lf", sent_log[0], 64'h00_4D_44_45_41_44_0D_0A);
        chk("overrun_set", 64'(ovf[0]), 64'h1);
        clear_logs();
        send(16'hCAFE, 1'b0);
        wait_idle();
        chk("seq_cafe_lf", sent_log[0], 64'h00_4D_43_41_46_45_0D_0A);
        chk("overrun_sticky", 64'(ovf[1]), 64'h1);

        // Asynchronous reset mid-message
        clear_logs();
        send(16'hF00D, 1'b0);
        tick();
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", 64'(bv[0]), 64'h0);
        chk("async_rst_byte", 64'(bo[0]), 64'h0);
        chk("async_rst_busy", 64'(bsy[0]), 64'h0);
        chk("async_rst_ovr", 64'(ovf[0]), 64'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        clear_logs();
        send(16'h1234, 1'b0);
        wait_idle();
        chk("seq_1234_lf", sent_log[0], 64'h00_4D_31_32_33_34_0D_0A);

        // Random traffic with random backpressure
        ready_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (valid_i) begin
                valid_i = 1'b0;
            end else begin
                data_i  = 16'($urandom);
                rw_i    = 1'($urandom_range(0, 1));
                valid_i = ($urandom_range(0, 5) == 0);
            end
        end
        tick();
        valid_i = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bridge_tx
